// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage in front of the data-memory port.
// Accepts one decoded request at a time, rejects misaligned or illegal
// encodings locally, issues a word-aligned byte-masked memory access and
// returns the aligned, extended load result (or ALU pass-through value).
module lsu_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state;
    logic [15:0] tmo_cnt;
    logic        ld_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        tmo_hit;

    // Encoding and alignment check applied to a memory request at acceptance.
    function automatic logic is_illegal(input logic ld, input logic st,
                                        input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (ld && st)
            bad = 1'b1;
        if (ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            bad = 1'b1;
        if (st && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010))
            bad = 1'b1;
        if (f3[1:0] == 2'b01 && off[0])
            bad = 1'b1;
        if (f3[1:0] == 2'b10 && off != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the narrow store value across all lanes so the mask picks it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Shift the addressed bytes down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [31:0] s;
        s = rd >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    // Saturating compare so a handshake taken on the last REQ cycle cannot skip the limit.
    assign tmo_hit   = (tmo_cnt >= 16'(MEM_TIMEOUT - 1));

    // Control FSM with registered memory-side and write-back-side outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tmo_cnt       <= 16'd0;
            ld_q          <= 1'b0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            mem_req_valid <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_wmask     <= 4'd0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ld_q  <= req_is_load;
                        f3_q  <= req_funct3;
                        off_q <= req_addr[1:0];
                        if (!req_is_load && !req_is_store) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= req_addr;
                            resp_err   <= 1'b0;
                        end else if (is_illegal(req_is_load, req_is_store,
                                                req_funct3, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                            resp_err   <= 1'b1;
                        end else begin
                            state         <= REQ;
                            tmo_cnt       <= 16'd0;
                            mem_req_valid <= 1'b1;
                            mem_wen       <= req_is_store;
                            mem_addr      <= {req_addr[31:2], 2'b00};
                            mem_wmask     <= req_is_store ? store_mask(req_funct3, req_addr[1:0]) : 4'd0;
                            mem_wdata     <= req_is_store ? store_data(req_funct3, req_wdata) : 32'd0;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end else if (tmo_hit) begin
                        mem_req_valid <= 1'b0;
                        state         <= RESP;
                        resp_valid    <= 1'b1;
                        resp_rdata    <= 32'd0;
                        resp_err      <= 1'b1;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (mem_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_q ? load_extract(mem_rdata, off_q, f3_q) : 32'd0;
                        resp_err   <= 1'b0;
                    end else if (tmo_hit) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scripted memory responder, latency and
// memory-field checks per transaction, result scoreboard on resp_valid.
module tb_lsu_ctrl;

    localparam int MT = 4;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_exp;
    int  checks = 0;
    int  errors = 0;

    lsu_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // Scoreboard: every write-back pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (reset && resp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
            end else begin
                mon_exp = sb_q.pop_front();
                if (resp_rdata !== mon_exp.rdata || resp_err !== mon_exp.err) begin
                    errors++;
                    $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             resp_rdata, resp_err, mon_exp.rdata, mon_exp.err);
                end
            end
        end
    end

    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    task automatic release_req();
        req_valid    = 1'b0;
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
    endtask

    // One full transaction with a scripted memory: rdy stall cycles, then rv
    // WAIT cycles before mem_rvalid (rv < 0: never respond).
    task automatic run_txn(input string name, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int rdy, input int rv,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic exp_mem, input logic exp_wen, input logic [31:0] exp_maddr,
                           input logic [3:0] exp_mask, input logic [31:0] exp_mwdata);
        int   need;
        int   exp_lat;
        int   lat;
        int   req_seen;
        int   wait_seen;
        logic in_wait;
        logic mem_seen;
        sb_t  e;
        need    = (rv < 0) ? 1000 : rdy + rv + 2;
        exp_lat = !exp_mem ? 1 : ((need > MT) ? MT + 1 : need + 1);
        lat = 0; req_seen = 0; wait_seen = 0; in_wait = 1'b0; mem_seen = 1'b0;

        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before: got %b, required 1", name, req_ready);
        end
        drive_req(ld, st, f3, addr, wd);
        mem_rdata = rd;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(posedge clock);
        #1 release_req();

        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = n;
                mem_req_ready = 1'b0;
                mem_rvalid    = 1'b0;
                break;
            end
            if (mem_req_valid) begin
                mem_seen = 1'b1;
                checks++;
                if ({mem_wen, mem_addr, mem_wmask} !== {exp_wen, exp_maddr, exp_mask}) begin
                    errors++;
                    $display("FAIL %s_mem_fields: got wen=%b addr=%h mask=%b, required wen=%b addr=%h mask=%b",
                             name, mem_wen, mem_addr, mem_wmask, exp_wen, exp_maddr, exp_mask);
                end
                if (exp_wen) begin
                    checks++;
                    if (mem_wdata !== exp_mwdata) begin
                        errors++;
                        $display("FAIL %s_mem_wdata: got %h, required %h", name, mem_wdata, exp_mwdata);
                    end
                end
                mem_req_ready = (req_seen >= rdy);
                mem_rvalid    = 1'b1;
                in_wait       = mem_req_ready;
                req_seen++;
            end else if (in_wait) begin
                mem_req_ready = 1'b0;
                mem_rvalid    = (rv >= 0) && (wait_seen >= rv);
                wait_seen++;
            end else begin
                mem_req_ready = 1'b0;
                mem_rvalid    = 1'b0;
            end
        end

        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (mem_seen !== exp_mem) begin
            errors++;
            $display("FAIL %s_mem_access: got %b, required %b", name, mem_seen, exp_mem);
        end
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_resp: got resp_valid=%b req_ready=%b, required 0 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req_ready=%b mem_req_valid=%b resp_valid=%b, required 1 0 0",
                     req_ready, mem_req_valid, resp_valid);
        end
        checks++;
        if ({mem_wen, mem_wmask, mem_addr, mem_wdata, resp_rdata, resp_err} !== 102'd0) begin
            errors++;
            $display("FAIL reset_data: got wen=%b mask=%b addr=%h wdata=%h rdata=%h err=%b, required all 0",
                     mem_wen, mem_wmask, mem_addr, mem_wdata, resp_rdata, resp_err);
        end
    endtask

    task automatic test_pass_through();
        run_txn("pass", 1'b0, 1'b0, 3'b000, 32'h8000_1234, 32'h0, 32'h0, 0, 0,
                32'h8000_1234, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_loads();
        run_txn("lb",  1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 0, 0,
                32'hFFFF_FF80, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 0, 0,
                32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lh",  1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_FFFF, 0, 0,
                32'hFFFF_80FF, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lhu", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h80FF_FFFF, 0, 0,
                32'h0000_80FF, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
        run_txn("lw",  1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'h1234_5678, 1, 1,
                32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 4'h0, 32'h0);
    endtask

    task automatic test_stores();
        run_txn("sh", 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'hDEAD_BEEF, 2, 0,
                32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1100, 32'hABCD_ABCD);
        run_txn("sb", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 0, 1,
                32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b0010, 32'hABAB_ABAB);
        run_txn("sw", 1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 32'h1111_2222, 0, 0,
                32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_0008, 4'b1111, 32'hDEAD_BEEF);
    endtask

    task automatic test_errors();
        run_txn("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0,
                32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        run_txn("lh_misaligned", 1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 0, 0,
                32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        run_txn("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 0, 0,
                32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        run_txn("ld_and_st", 1'b1, 1'b1, 3'b000, 32'h8000_0000, 32'h0, 32'h0, 0, 0,
                32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        run_txn("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0,
                32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_timeout();
        run_txn("tmo_wait", 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h5555_AAAA, 0, -1,
                32'h0, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
        run_txn("tmo_req", 1'b0, 1'b1, 3'b010, 32'h8000_0014, 32'h0BAD_F00D, 32'h0, 99, 0,
                32'h0, 1'b1, 1'b1, 1'b1, 32'h8000_0014, 4'b1111, 32'h0BAD_F00D);
        // Late response arriving with the stage idle must be dropped.
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            @(negedge clock);
            checks++;
            if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL stray_rvalid: got resp_valid=%b mem_req_valid=%b req_ready=%b, required 0 0 1",
                         resp_valid, mem_req_valid, req_ready);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic abort_check(input string name);
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got mem_req_valid=%b req_ready=%b, required 0 1", name, mem_req_valid, req_ready);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_no_resp: got resp_valid=%b, required 0", name, resp_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Abort while waiting for the response.
        @(negedge clock);
        drive_req(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
        @(posedge clock);
        #1 release_req();
        @(negedge clock);
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        reset = 1'b0;
        abort_check("reset_in_wait");
        // Abort while the request is still being offered.
        @(negedge clock);
        drive_req(1'b0, 1'b1, 3'b010, 32'h8000_0024, 32'hCAFE_0001);
        @(posedge clock);
        #1 release_req();
        @(negedge clock);
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_req_pre: got mem_req_valid=%b, required 1", mem_req_valid);
        end
        reset = 1'b0;
        abort_check("reset_in_req");
        run_txn("after_reset", 1'b1, 1'b0, 3'b000, 32'h8000_0021, 32'h0, 32'h0000_7F00, 0, 0,
                32'h0000_007F, 1'b0, 1'b1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        sb_t e;
        @(negedge clock);
        drive_req(1'b0, 1'b0, 3'b000, 32'h0000_00A1, 32'h0);
        e.rdata = 32'h0000_00A1; e.err = 1'b0;
        sb_q.push_back(e);
        @(posedge clock);
        #1 drive_req(1'b0, 1'b0, 3'b000, 32'h0000_00B2, 32'h0);
        e.rdata = 32'h0000_00B2; e.err = 1'b0;
        sb_q.push_back(e);
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cycle1: got resp_valid=%b req_ready=%b, required 1 0", resp_valid, req_ready);
        end
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cycle2: got resp_valid=%b req_ready=%b, required 0 1", resp_valid, req_ready);
        end
        @(posedge clock);
        #1 release_req();
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_cycle3: got resp_valid=%b, required 1", resp_valid);
        end
        @(negedge clock);
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_is_load   = 1'b0;
        req_is_store  = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        @(negedge clock);
        reset = 1'b1;

        test_pass_through();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending responses, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage that sits directly upstream of the data-memory port in the NPC core. It takes one decoded load/store request per transaction from execute and checks alignment and encoding. It issues a word-aligned, byte-masked access to memory over a valid/ready request and valid response handshake, then returns an aligned, sign- or zero-extended result to write-back. Non-memory instructions pass their ALU result straight through with no memory access.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in REQ+WAIT before the access is abandoned with an error; legal range 2..65535.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  request from execute
- req_ready  out  1  stage can accept a request
- req_is_load  in  1  request is a load
- req_is_store  in  1  request is a store
- req_funct3  in  3  RV32I width/sign encoding
- req_addr  in  32  byte address, or ALU result for pass-through
- req_wdata  in  32  store data, right-justified
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  1 = write, 0 = read
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte-lane enables (0 for reads)
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  32  read word
- resp_valid  out  1  one-cycle result pulse to write-back
- resp_rdata  out  32  load result, or pass-through value
- resp_err  out  1  misaligned, illegal, or timed-out access

## Operation
- States: IDLE, REQ, WAIT, RESP. Encoding is free.
- req_ready = (state == IDLE). All request fields are registered on acceptance (req_valid & req_ready).
- Acceptance in IDLE is classified as follows:
  - Pass-through (neither load nor store): go to RESP with resp_rdata = req_addr and err = 0.
  - Error, go to RESP with resp_rdata = 0 and err = 1, no memory access, for any of:
    - load and store both set;
    - load funct3 in {011, 110, 111};
    - store funct3 not in {000, 001, 010};
    - halfword access with addr[0] = 1;
    - word access with addr[1:0] != 0.
  - Otherwise go to REQ.
- Store mask and data:
  - SB: mask = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: mask = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: mask = 4'b1111, wdata unchanged.
- Load result: let s = mem_rdata >> (8*addr[1:0]).
  - LB / LBU: sign- / zero-extend s[7:0].
  - LH / LHU: sign- / zero-extend s[15:0].
  - LW: s.
- REQ: mem_req_valid = 1. mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready is sampled high, then go to WAIT.
- WAIT: on mem_rvalid, capture the extracted load data (stores: rdata = 0) and go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no backpressure from write-back.
- Timeout: the counter clears on entering REQ and increments every cycle in REQ or WAIT. When it reaches MEM_TIMEOUT-1 without a completing handshake, the block goes to RESP with err = 1 and rdata = 0. If a completing handshake occurs on that same cycle, the handshake wins (normal completion).
- mem_rvalid is ignored outside WAIT, including in REQ and for stray or late responses in IDLE.

## Timing
- Reset values:
  - state = IDLE and req_ready = 1;
  - mem_req_valid, mem_wen, mem_wmask, mem_addr and mem_wdata = 0;
  - resp_valid, resp_rdata and resp_err = 0;
  - timeout counter = 0.
- Reset asserted mid-transaction aborts immediately. No response is produced, and mem_req_valid drops asynchronously.
- Memory outputs are registered; mem_req_valid is high only in REQ. resp_* are registered and valid only while resp_valid = 1.
- Error or pass-through: accepted at edge 0, resp_valid high in cycle 1, req_ready high again in cycle 2.
- Best-case memory access: accept at edge 0; REQ in cycle 1 with mem_req_ready = 1; WAIT in cycle 2 with mem_rvalid = 1; RESP in cycle 3. That is 3 cycles from acceptance to resp_valid.
- Each stall cycle on mem_req_ready or mem_rvalid adds exactly one cycle.
- Throughput: at most one transaction in flight; a new request is accepted only in IDLE.

## Test plan
- Pass-through: is_load = 0, is_store = 0, addr = 0x8000_1234 -> resp_valid in cycle 1, rdata = 0x8000_1234, err = 0, mem_req_valid never high.
- LB sign extension: addr = 0x8000_0003, memory returns 0x80FF_FFFF with ready and rvalid immediate -> resp_rdata = 0xFFFF_FF80 in cycle 3. LBU at the same address -> 0x0000_0080.
- SH at addr = 0x8000_0002, wdata = 0x1234_ABCD -> mem_wen = 1, mem_addr = 0x8000_0000, mem_wmask = 4'b1100, mem_wdata = 0xABCD_ABCD. mem_req_ready held low 2 cycles -> resp_valid in cycle 5, err = 0.
- Misaligned and illegal: LW at 0x8000_0002, LH at 0x8000_0001, and store funct3 = 100 -> each gives resp_err = 1 in cycle 1 with no memory request.
- Timeout: MEM_TIMEOUT = 4, mem_req_ready = 1, mem_rvalid never asserted -> resp_err = 1 with rdata = 0. A later stray mem_rvalid in IDLE is ignored.
- Reset while in WAIT (reset = 0 for one cycle) -> mem_req_valid = 0 and req_ready = 1 immediately, no resp_valid. The next request completes normally.
